// File: rtl/gesummv_ctrl_if.sv
// ============================================================================
// Module      : gesummv_ctrl_if
// Description : Start/operand-fetch/result bundle for the GESUMMV controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gesummv_ctrl_if;
    logic        start;
    logic [3:0]  alpha;
    logic [3:0]  beta;
    logic        mem_rd;
    logic [3:0]  mem_addr;
    logic [3:0]  a_data;
    logic [3:0]  b_data;
    logic [3:0]  x_data;
    logic [15:0] y_data;
    logic [1:0]  y_idx;
    logic        y_valid;
    logic        y_ready;
    logic        busy;
    logic        done;

    // Controller side
    modport slave (
        input  start, alpha, beta, a_data, b_data, x_data, y_ready,
        output mem_rd, mem_addr, y_data, y_idx, y_valid, busy, done
    );

    // Requester / operand store / result consumer side
    modport master (
        output start, alpha, beta, a_data, b_data, x_data, y_ready,
        input  mem_rd, mem_addr, y_data, y_idx, y_valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/gesummv_ctrl.sv
// ============================================================================
// Module      : gesummv_ctrl
// Description : Row-serial y = alpha*A*x + beta*B*x controller, 4x4 operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gesummv_ctrl #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    gesummv_ctrl_if.slave    bus
);

    localparam logic [1:0] c_LAST_COL = 2'(N - 1);
    localparam logic [1:0] c_LAST_ROW = 2'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LAST  = 3'd2,
        S_SCALE = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic [3:0]  alpha_q, alpha_d;
    logic [3:0]  beta_q, beta_d;
    logic [9:0]  acc_a_q, acc_a_d;
    logic [9:0]  acc_b_q, acc_b_d;
    logic [15:0] y_q, y_d;
    logic [1:0]  yidx_q, yidx_d;
    logic        rd_q;

    logic        w_rd;
    logic [7:0]  w_pa;
    logic [7:0]  w_pb;
    logic [13:0] w_sa;
    logic [13:0] w_sb;
    logic [14:0] w_sum;

    assign w_rd  = (state_q == S_READ);
    assign w_pa  = bus.a_data * bus.x_data;
    assign w_pb  = bus.b_data * bus.x_data;
    assign w_sa  = alpha_q * acc_a_q;
    assign w_sb  = beta_q * acc_b_q;
    assign w_sum = {1'b0, w_sa} + {1'b0, w_sb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            alpha_q <= 4'd0;
            beta_q  <= 4'd0;
            acc_a_q <= 10'd0;
            acc_b_q <= 10'd0;
            y_q     <= 16'd0;
            yidx_q  <= 2'd0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            alpha_q <= alpha_d;
            beta_q  <= beta_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            y_q     <= y_d;
            yidx_q  <= yidx_d;
            rd_q    <= w_rd;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        y_d     = y_q;
        yidx_d  = yidx_q;

        // Operands arrive one cycle after the strobe, so the delayed strobe
        // (not the state) qualifies accumulation; this covers the LAST cycle.
        if (rd_q) begin
            acc_a_d = acc_a_q + {2'b00, w_pa};
            acc_b_d = acc_b_q + {2'b00, w_pb};
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    alpha_d = bus.alpha;
                    beta_d  = bus.beta;
                    row_d   = 2'd0;
                    col_d   = 2'd0;
                    acc_a_d = 10'd0;
                    acc_b_d = 10'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // col stays at the last index so mem_addr holds while idle
                if (col_q == c_LAST_COL) begin
                    state_d = S_LAST;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            S_LAST: begin
                state_d = S_SCALE;
            end
            S_SCALE: begin
                y_d     = {1'b0, w_sum};
                yidx_d  = row_q;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.y_ready) begin
                    if (row_q == c_LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 2'd1;
                        col_d   = 2'd0;
                        acc_a_d = 10'd0;
                        acc_b_d = 10'd0;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_rd   = w_rd;
    assign bus.mem_addr = {row_q, col_q};
    assign bus.y_data   = y_q;
    assign bus.y_idx    = yidx_q;
    assign bus.y_valid  = (state_q == S_OUT);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_gesummv_ctrl.sv
// ============================================================================
// Module      : tb_gesummv_ctrl
// Description : Directed self-checking bench for gesummv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gesummv_ctrl;

    logic clk;
    logic rst_n;

    gesummv_ctrl_if bus ();

    gesummv_ctrl #(.N(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  a_m [16];
    logic [3:0]  b_m [16];
    logic [3:0]  x_m [4];
    logic [15:0] exp_y [4];

    int n_cmp = 0;
    int n_err = 0;

    // Operand store: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.a_data <= a_m[bus.mem_addr];
            bus.b_data <= b_m[bus.mem_addr];
            bus.x_data <= x_m[bus.mem_addr[1:0]];
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic load_ops(input bit all15);
        for (int i = 0; i < 4; i++) begin
            x_m[i] = all15 ? 4'd15 : 4'(i);
            for (int j = 0; j < 4; j++) begin
                a_m[i*4+j] = all15 ? 4'd15 : 4'(i + j);
                b_m[i*4+j] = all15 ? 4'd15 : 4'(i + j + 1);
            end
        end
    endtask

    task automatic set_exp(input int e0, input int e1, input int e2, input int e3);
        exp_y[0] = 16'(e0);
        exp_y[1] = 16'(e1);
        exp_y[2] = 16'(e2);
        exp_y[3] = 16'(e3);
    endtask

    // One full pass; optional 5-cycle stall at stall_row, extra start pulses,
    // and alpha/beta disturbance after acceptance.
    task automatic do_pass(input logic [3:0] a, input logic [3:0] b,
                           input int stall_row, input bit extra, input bit chg);
        int hs, dn, dcyc, stall, post;
        bit chk_next, fin;
        logic [15:0] held;
        hs = 0; dn = 0; dcyc = 0; stall = 0; post = 0;
        chk_next = 0; fin = 0; held = '0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.alpha   = a;
        bus.beta    = b;
        bus.y_ready = (stall_row == 0) ? 1'b0 : 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == 1) begin
                check("busy_after_start", int'(bus.busy), 1);
                if (chg) begin
                    bus.alpha = ~a;
                    bus.beta  = ~b;
                end
            end
            if (chk_next) begin
                check("next_row_rd", int'(bus.mem_rd), 1);
                check("next_row_addr", int'(bus.mem_addr), (stall_row + 1) * 4);
                chk_next = 0;
            end
            if (bus.y_valid && !bus.y_ready) begin
                stall++;
                if (stall == 1) held = bus.y_data;
                else check("stall_hold", int'(bus.y_data), int'(held));
                check("stall_no_rd", int'(bus.mem_rd), 0);
                if (stall == 5) bus.y_ready = 1'b1;
            end else if (bus.y_valid && bus.y_ready) begin
                check("y_idx", int'(bus.y_idx), hs);
                check("y_data", int'(bus.y_data), int'(exp_y[hs & 3]));
                if (int'(bus.y_idx) == stall_row) chk_next = 1;
                hs++;
                if (hs == stall_row) bus.y_ready = 1'b0;
            end
            if (extra && bus.mem_rd && bus.mem_addr == 4'b1001) bus.start = 1'b1;
            if (bus.done) begin
                dn++;
                if (dn == 1) dcyc = cyc;
                check("busy_in_done", int'(bus.busy), 1);
                if (extra) bus.start = 1'b1;
            end
            if (dn > 0) begin
                post++;
                if (post == 3) fin = 1;
            end
        end
        if (!fin) check("pass_timeout", 0, 1);
        check("handshakes", hs, 4);
        check("done_pulses", dn, 1);
        check("done_cycle", dcyc, (stall_row >= 0) ? 34 : 29);
        if (stall_row >= 0) check("stall_cycles", stall, 5);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_valid", int'(bus.y_valid), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.alpha   = 4'd0;
        bus.beta    = 4'd0;
        bus.y_ready = 1'b1;
        bus.a_data  = 4'd0;
        bus.b_data  = 4'd0;
        bus.x_data  = 4'd0;
        load_ops(1'b0);
        #12;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_mem_rd", int'(bus.mem_rd), 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_y_valid", int'(bus.y_valid), 0);
        check("rst_y_data", int'(bus.y_data), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        set_exp(34, 46, 58, 70);
        do_pass(4'd1, 4'd1, -1, 1'b0, 1'b0);

        set_exp(374, 506, 638, 770);
        do_pass(4'd11, 4'd11, -1, 1'b0, 1'b1);

        load_ops(1'b1);
        set_exp(27000, 27000, 27000, 27000);
        do_pass(4'd15, 4'd15, -1, 1'b0, 1'b0);

        load_ops(1'b0);
        set_exp(154, 220, 286, 352);
        do_pass(4'd11, 4'd0, 1, 1'b0, 1'b0);

        set_exp(34, 46, 58, 70);
        do_pass(4'd1, 4'd1, -1, 1'b1, 1'b0);

        // Abort mid-pass during row 2 reads
        @(negedge clk);
        bus.start = 1'b1;
        bus.alpha = 4'd1;
        bus.beta  = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        begin
            bit hit;
            hit = 0;
            for (int c = 0; c < 100 && !hit; c++) begin
                @(negedge clk);
                if (bus.mem_rd && bus.mem_addr[3:2] == 2'd2) hit = 1;
            end
            check("reached_row2", int'(hit), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_rd", int'(bus.mem_rd), 0);
        check("arst_mem_addr", int'(bus.mem_addr), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_y_data", int'(bus.y_data), 0);
        check("arst_y_idx", int'(bus.y_idx), 0);
        check("arst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_pass(4'd1, 4'd1, -1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gesummv_ctrl.md
GESUMMV_CTRL -- requirements
Module: gesummv_ctrl

Interface
REQ-001 Parameter: N, 4, matrix dimension; fixed at 4 in this revision (2-bit row/column indices).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request one full GESUMMV pass; sampled only in IDLE.
REQ-005 alpha  in  4  unsigned scalar for A*x; captured on accepted start.
REQ-006 beta  in  4  unsigned scalar for B*x; captured on accepted start.
REQ-007 mem_rd  out  1  operand read strobe to the A/B/x store.
REQ-008 mem_addr  out  4  {row[1:0], col[1:0]}; A/B indexed by row and col, x indexed by col.
REQ-009 a_data, b_data, x_data  in  4 each  unsigned operands, valid exactly one cycle after mem_rd.
REQ-010 y_data  out  16  y[row] = alpha*(A[row]·x) + beta*(B[row]·x), zero-extended.
REQ-011 y_idx  out  2  row index of y_data.
REQ-012 y_valid  out  1  y_data/y_idx valid; held until y_ready.
REQ-013 y_ready  in  1  consumer accepts y when y_valid and y_ready are both high.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of a pass.

Function
REQ-016 FSM states SHALL be IDLE, READ, LAST, SCALE, OUT, DONE.
REQ-017 IDLE: start=1 -> capture alpha/beta, row=0, col=0, clear acc_a/acc_b, go READ; start=0 -> stay.
REQ-018 READ: mem_rd=1, mem_addr={row,col}, col increments each cycle; after issuing col=3 -> LAST; exactly 4 reads per row.
REQ-019 Each cycle following a mem_rd: acc_a += a_data*x_data, acc_b += b_data*x_data; products 8-bit, accumulators 10-bit, no overflow possible.
REQ-020 LAST: mem_rd=0; accumulate the col=3 data; -> SCALE.
REQ-021 SCALE: register y_data = alpha*acc_a + beta*acc_b (15-bit result zero-extended to 16), y_idx=row; -> OUT.
REQ-022 OUT: y_valid=1, y_data/y_idx stable; on y_ready: row=3 -> DONE, else row++, col=0, clear accumulators, -> READ; no y_ready -> stay (unbounded backpressure).
REQ-023 DONE: done=1 for one cycle, busy=1; -> IDLE.
REQ-024 With y_ready held high: 7 cycles per row; first y_valid in the 7th cycle after the start-accept edge; done in the 29th cycle after it.
REQ-025 start while busy SHALL be ignored (no restart, no queuing); alpha/beta changes during a pass SHALL have no effect.
REQ-026 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle is accepted.
REQ-027 mem_rd SHALL be 0 outside READ; y_valid SHALL be 0 outside OUT; mem_addr SHALL hold its last value when mem_rd=0.
REQ-028 Accumulation SHALL be driven by a registered copy of mem_rd (1-cycle delay), not by the FSM state.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, row=col=0, accumulators=0, alpha=beta=0, y_data=0, y_idx=0, mem_addr=0, and mem_rd, y_valid, busy, done=0.
REQ-030 Reset mid-pass SHALL abort the pass with no further y output or done pulse; the first start after release begins a new pass at row 0.

Verification
REQ-031 A[i][j]=i+j, B[i][j]=i+j+1, x[j]=j, alpha=beta=1, y_ready=1 -> y_idx 0..3, y_data 34,46,58,70; done in the 29th cycle after start-accept.
REQ-032 Same operands, alpha=beta=11 -> y_data 374,506,638,770.
REQ-033 All operands 15, alpha=beta=15 -> every y_data=27000 (no truncation).
REQ-034 alpha=11, beta=0, y_ready low for 5 cycles at row 1 -> y_data=220 (11*20) held stable with y_valid high throughout, no mem_rd while stalled, row 2 starts the cycle after handshake.
REQ-035 start pulsed again at row 2, and again in the DONE cycle -> both ignored, exactly 4 y handshakes and one done pulse.
REQ-036 rst_n low during READ of row 2 -> all outputs 0 asynchronously; new start -> first output y_idx=0 with correct value.
